platform_pio_debounce: RTL and testbench
========================================

PLATFORM_PIO_DEBOUNCE -- requirements
Module: platform_pio_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable synchronized cycles required before a clean-level change; legal range 2..65535.
REQ-002 Port clk  input  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high.
REQ-004 Port address  input  2  Avalon-MM slave register select.
REQ-005 Port chipselect  input  1  Avalon-MM slave select.
REQ-006 Port write_n  input  1  Avalon-MM write strobe, active low.
REQ-007 Port writedata  input  32  Avalon-MM write data.
REQ-008 Port readdata  output  32  Avalon-MM read data, registered.
REQ-009 Port pins_in  input  2  raw, asynchronous external pin levels.
REQ-010 Port clean_out  output  2  debounced levels, feeding the downstream 2-bit PIO port.
REQ-011 Port irq  output  1  level interrupt request, active high.

Function
REQ-012 Each pins_in bit SHALL pass through a 2-flop synchronizer; sync output = pins_in delayed 2 cycles.
REQ-013 Per channel: a 16-bit counter SHALL increment each cycle when sync != clean; the counter SHALL clear to 0 in any cycle when sync == clean.
REQ-014 When sync != clean and counter == DEBOUNCE_CYCLES-1, clean SHALL take the sync value next edge and the counter SHALL clear.
REQ-015 Pin-to-clean_out latency for a stable change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles; any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never reach clean_out.
REQ-016 Channels SHALL be fully independent; a glitch on one SHALL NOT affect the other's counter.
REQ-017 Register map: addr 0 = clean levels [1:0] (read-only, writes ignored); addr 1 = irq_mask [1:0] (R/W); addr 2 = edge_capture [1:0] (read, write-1-to-clear); addr 3 = edge_cfg [3:0], rise_en in bits [1:0], fall_en in bits [3:2] (R/W).
REQ-018 Writes SHALL occur when chipselect=1 and write_n=0; unused writedata bits ignored.
REQ-019 readdata SHALL update every cycle to the zero-extended value of the addressed register, independent of chipselect; read latency 1 cycle; reads have no side effects.
REQ-020 edge_capture[i] SHALL set on the cycle clean[i] goes 0->1 with rise_en[i]=1, or 1->0 with fall_en[i]=1; it SHALL stay set until cleared.
REQ-021 Simultaneous set event and write-1-to-clear on the same bit: set SHALL win.
REQ-022 irq SHALL equal OR of (edge_capture & irq_mask), combinational from registers, no extra latency.
REQ-023 Changing edge_cfg or irq_mask SHALL NOT alter edge_capture; unmasking an already-set bit SHALL assert irq the next cycle after the write.
REQ-024 Counters SHALL never wrap; reaching DEBOUNCE_CYCLES-1 always resolves per REQ-014.

Reset
REQ-025 On reset assertion, synchronizer flops, counters, clean_out, irq_mask, edge_capture, edge_cfg, and readdata SHALL immediately become 0; irq SHALL be 0.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count; after release the full 2 + DEBOUNCE_CYCLES latency applies anew.
REQ-027 A pin high at reset release SHALL drive clean_out to 1 after 2 + DEBOUNCE_CYCLES cycles; no capture results since edge_cfg resets to 0.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 pins_in 00->01 held -> clean_out=01 exactly 6 cycles later; addr 0 read returns 0x1.
REQ-029 pins_in[0] high for 3 cycles then low -> clean_out stays 00, edge_capture stays 0.
REQ-030 edge_cfg=0x1, irq_mask=0x1, pin0 rises -> edge_capture=0x1, irq=1; write 0x1 to addr 2 -> irq=0 next cycle.
REQ-031 Write-1-to-clear addr 2 on the same cycle a new rising edge sets bit 0 -> edge_capture bit 0 remains 1.
REQ-032 edge_cfg=0xC, both pins fall simultaneously, irq_mask=0 -> edge_capture=0x3, irq=0; then write irq_mask=0x2 -> irq=1.
REQ-033 Assert reset at debounce count 2 on pin 1, release with pin held high -> clean_out[1]=1 exactly 6 cycles after release; all registers read 0 beforehand.

Source files
------------

// File: rtl/platform_pio_debounce_if.sv
// Avalon-MM slave bus bundle for the two-channel debounced PIO block.
// The master modport is the bus host side; the slave modport is the register file side.
interface platform_pio_debounce_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/platform_pio_debounce.sv
// Two-channel pin debouncer with edge capture, irq masking and an Avalon-MM register file.
// Each pin is synchronized, then must differ from the clean level for DEBOUNCE_CYCLES cycles.
module platform_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    platform_pio_debounce_if.slave   avs,
    input  logic [1:0]               pins_in,
    output logic [1:0]               clean_out,
    output logic                     irq
);

    localparam logic [15:0] TERM_CNT = 16'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_CLEAN = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_CFG   = 2'd3;

    logic [1:0]  meta_q, meta_d;
    logic [1:0]  sync_q, sync_d;
    logic [1:0]  clean_q, clean_d;
    logic [15:0] cnt_q [2];
    logic [15:0] cnt_d [2];
    logic [1:0]  irq_mask_q, irq_mask_d;
    logic [1:0]  edge_cap_q, edge_cap_d;
    logic [3:0]  edge_cfg_q, edge_cfg_d;
    logic [31:0] readdata_q, readdata_d;

    logic        wr_en;
    logic [1:0]  rise_evt;
    logic [1:0]  fall_evt;
    logic [1:0]  clr_mask;
    logic        wdata_unused;

    assign wdata_unused = ^avs.writedata[31:4];

    // Synchronizer and per-channel debounce counters
    always_comb begin
        meta_d  = pins_in;
        sync_d  = meta_q;
        clean_d = clean_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = 16'd0;
            if (sync_q[i] != clean_q[i]) begin
                if (cnt_q[i] == TERM_CNT) begin
                    clean_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Edge detection uses the next clean value so capture lands on the same edge as clean_out.
    always_comb begin
        wr_en    = avs.chipselect & ~avs.write_n;
        rise_evt = clean_d & ~clean_q & edge_cfg_q[1:0];
        fall_evt = ~clean_d & clean_q & edge_cfg_q[3:2];
        clr_mask = 2'b00;
        if (wr_en && (avs.address == ADDR_EDGE)) begin
            clr_mask = avs.writedata[1:0];
        end
        edge_cap_d = (edge_cap_q & ~clr_mask) | rise_evt | fall_evt;
    end

    always_comb begin
        irq_mask_d = irq_mask_q;
        edge_cfg_d = edge_cfg_q;
        if (wr_en && (avs.address == ADDR_MASK)) begin
            irq_mask_d = avs.writedata[1:0];
        end
        if (wr_en && (avs.address == ADDR_CFG)) begin
            edge_cfg_d = avs.writedata[3:0];
        end
    end

    always_comb begin
        readdata_d = 32'd0;
        case (avs.address)
            ADDR_CLEAN: readdata_d = {30'd0, clean_q};
            ADDR_MASK:  readdata_d = {30'd0, irq_mask_q};
            ADDR_EDGE:  readdata_d = {30'd0, edge_cap_q};
            ADDR_CFG:   readdata_d = {28'd0, edge_cfg_q};
            default:    readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q     <= 2'b00;
            sync_q     <= 2'b00;
            clean_q    <= 2'b00;
            cnt_q[0]   <= 16'd0;
            cnt_q[1]   <= 16'd0;
            irq_mask_q <= 2'b00;
            edge_cap_q <= 2'b00;
            edge_cfg_q <= 4'h0;
            readdata_q <= 32'd0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            clean_q    <= clean_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            edge_cfg_q <= edge_cfg_d;
            readdata_q <= readdata_d;
        end
    end

    assign clean_out    = clean_q;
    assign avs.readdata = readdata_q;
    assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_platform_pio_debounce.sv
// Bench for platform_pio_debounce: directed corner scenarios plus randomized traffic,
// scored every cycle against a window-based reference model.
module tb_platform_pio_debounce;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic [1:0] pins;
    logic [1:0] clean_out;
    logic       irq;

    platform_pio_debounce_if bus ();

    platform_pio_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .avs       (bus),
        .pins_in   (pins),
        .clean_out (clean_out),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        bit [1:0]  clean;
        bit        irq;
        bit [31:0] rd;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a channel flips when its last D synchronized samples all oppose clean.
    bit [1:0] pin_hist[$];
    bit [1:0] m_clean, m_mask, m_cap;
    bit [3:0] m_cfg;

    always @(posedge clk) begin
        exp_t      e;
        bit [1:0]  nc;
        bit [1:0]  setv;
        bit [1:0]  clr;
        bit [31:0] rd;
        bit        stable;
        bit        wr;
        bit        v;
        int        idx;
        if (reset) begin
            pin_hist.delete();
            pin_hist.push_back(2'b00);
            pin_hist.push_back(2'b00);
            m_clean = 0; m_mask = 0; m_cap = 0; m_cfg = 0;
            e = '{2'b00, 1'b0, 32'd0};
        end else begin
            case (bus.address)
                2'd0:    rd = {30'd0, m_clean};
                2'd1:    rd = {30'd0, m_mask};
                2'd2:    rd = {30'd0, m_cap};
                default: rd = {28'd0, m_cfg};
            endcase
            pin_hist.push_back(pins);
            if (pin_hist.size() > 64) void'(pin_hist.pop_front());
            nc = m_clean;
            for (int ch = 0; ch < 2; ch++) begin
                stable = 1'b1;
                for (int j = 0; j < D; j++) begin
                    idx = pin_hist.size() - 3 - j;
                    v = (idx >= 0) ? pin_hist[idx][ch] : 1'b0;
                    if (v == m_clean[ch]) stable = 1'b0;
                end
                if (stable) nc[ch] = ~m_clean[ch];
            end
            setv = (nc & ~m_clean & m_cfg[1:0]) | (~nc & m_clean & m_cfg[3:2]);
            wr = bus.chipselect && !bus.write_n;
            clr = (wr && bus.address == 2'd2) ? bus.writedata[1:0] : 2'b00;
            m_cap = (m_cap & ~clr) | setv;
            if (wr && bus.address == 2'd1) m_mask = bus.writedata[1:0];
            if (wr && bus.address == 2'd3) m_cfg  = bus.writedata[3:0];
            m_clean = nc;
            e = '{m_clean, |(m_cap & m_mask), rd};
        end
        exp_q.push_back(e);
    end

    // Monitor: outputs are presented every cycle; sample mid-cycle.
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                if (reset) e = '{2'b00, 1'b0, 32'd0};
                chk("sb_clean", {30'd0, clean_out}, {30'd0, e.clean});
                chk("sb_irq", {31'd0, irq}, {31'd0, e.irq});
                chk("sb_readdata", bus.readdata, e.rd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold;
        reset          = 1'b1;
        pins           = 2'b00;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        repeat (3) step();
        chk("rst_clean", {30'd0, clean_out}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_readdata", bus.readdata, 32'd0);
        reset = 1'b0;
        repeat (2) step();

        // stable rise: exactly 2 + D cycles
        pins = 2'b01;
        repeat (5) step();
        chk("lat_minus1", {30'd0, clean_out}, 32'd0);
        step();
        chk("lat_exact", {30'd0, clean_out}, 32'd1);
        step();
        chk("rd_clean", bus.readdata, 32'd1);

        // short glitch is filtered
        pins = 2'b00;
        repeat (8) step();
        wr(2'd3, 32'hF);
        pins = 2'b01;
        repeat (3) step();
        pins = 2'b00;
        repeat (10) step();
        chk("glitch_clean", {30'd0, clean_out}, 32'd0);
        bus.address = 2'd2;
        step();
        chk("glitch_cap", bus.readdata, 32'd0);

        // rise capture, irq, write-1-to-clear
        wr(2'd3, 32'h1);
        wr(2'd1, 32'h1);
        pins = 2'b01;
        repeat (7) step();
        chk("rise_irq", {31'd0, irq}, 32'd1);
        bus.address = 2'd2;
        step();
        chk("rise_cap", bus.readdata, 32'd1);
        wr(2'd2, 32'h1);
        chk("w1c_irq", {31'd0, irq}, 32'd0);

        // clear on the same edge as a new set: set wins
        pins = 2'b00;
        repeat (8) step();
        pins = 2'b01;
        repeat (5) step();
        chk("race_pre_clean", {30'd0, clean_out}, 32'd0);
        wr(2'd2, 32'h1);
        chk("race_clean", {30'd0, clean_out}, 32'd1);
        chk("race_irq", {31'd0, irq}, 32'd1);
        bus.address = 2'd2;
        step();
        chk("race_cap", bus.readdata, 32'd1);

        // simultaneous falls, masked then unmasked
        wr(2'd1, 32'h0);
        wr(2'd3, 32'h0);
        pins = 2'b11;
        repeat (8) step();
        wr(2'd2, 32'h3);
        wr(2'd3, 32'hC);
        pins = 2'b00;
        repeat (8) step();
        chk("fall_clean", {30'd0, clean_out}, 32'd0);
        chk("fall_irq_masked", {31'd0, irq}, 32'd0);
        bus.address = 2'd2;
        step();
        chk("fall_cap", bus.readdata, 32'd3);
        wr(2'd1, 32'h2);
        chk("unmask_irq", {31'd0, irq}, 32'd1);

        // reset mid-debounce restarts the full latency
        pins = 2'b00;
        repeat (8) step();
        pins = 2'b10;
        repeat (4) step();
        reset = 1'b1;
        step();
        chk("mid_rst_clean", {30'd0, clean_out}, 32'd0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.address = 2'(k);
            step();
            chk("post_rst_clean", {30'd0, clean_out}, 32'd0);
            chk("post_rst_reg", bus.readdata, 32'd0);
        end
        step();
        chk("post_rst_lat", {30'd0, clean_out}, 32'h2);

        // randomized traffic, scored by the monitor
        hold = 0;
        for (int n = 0; n < 1500; n++) begin
            if (hold == 0) begin
                pins = 2'($urandom);
                hold = $urandom_range(1, 9);
            end
            bus.address   = 2'($urandom);
            bus.writedata = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
            end else begin
                bus.chipselect = 1'($urandom);
                bus.write_n    = 1'b1;
            end
            reset = ($urandom_range(0, 199) == 0);
            step();
            hold--;
        end
        reset          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        repeat (12) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
